// File: rtl/bsg_fifo_tracker_multi_pkg.sv
// rtl/bsg_fifo_tracker_multi_pkg.sv - width helpers and pointer type for the multi-entry FIFO tracker
package bsg_fifo_tracker_pkg;

  function automatic int ptr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  function automatic int cnt_width(input int max_add);
    return $clog2(max_add + 1);
  endfunction

  function automatic int occ_width(input int els);
    return $clog2(els + 1);
  endfunction

  localparam int ELS_DEF     = 128;
  localparam int MAX_ADD_DEF = 10;
  localparam int PTR_W_DEF   = ptr_width(ELS_DEF);

  // Consumers redeclare ptr_t locally from their own els_p.
  typedef logic [PTR_W_DEF-1:0] ptr_t;

endpackage

// File: rtl/bsg_fifo_tracker_multi_if.sv
// rtl/bsg_fifo_tracker_multi_if.sv - producer/consumer handshake and status bundle for the tracker
interface bsg_fifo_tracker_multi_if
  import bsg_fifo_tracker_pkg::*;
#(
  parameter int els_p     = 128,
  parameter int max_add_p = 10
);
  localparam int ptr_w = ptr_width(els_p);
  localparam int cnt_w = cnt_width(max_add_p);
  localparam int occ_w = occ_width(els_p);

  logic             enq_v_i;
  logic [cnt_w-1:0] enq_count_i;
  logic             enq_ready_o;
  logic             deq_v_i;
  logic [cnt_w-1:0] deq_count_i;
  logic             deq_ready_o;
  logic [ptr_w-1:0] wptr_o;
  logic [ptr_w-1:0] rptr_o;
  logic [occ_w-1:0] occ_o;
  logic             full_o;
  logic             empty_o;

  modport master (
    output enq_v_i, enq_count_i, deq_v_i, deq_count_i,
    input  enq_ready_o, deq_ready_o, wptr_o, rptr_o, occ_o, full_o, empty_o
  );

  modport slave (
    input  enq_v_i, enq_count_i, deq_v_i, deq_count_i,
    output enq_ready_o, deq_ready_o, wptr_o, rptr_o, occ_o, full_o, empty_o
  );

endinterface

// File: rtl/bsg_fifo_tracker_multi_ptr.sv
// rtl/bsg_fifo_tracker_multi_ptr.sv - modulo-els_p pointer advancing by up to max_add_p per cycle
module bsg_circ_ptr_arst_n
  import bsg_fifo_tracker_pkg::*;
#(
  parameter int  els_p     = 128,
  parameter int  max_add_p = 10,
  localparam int ptr_w     = ptr_width(els_p),
  localparam int cnt_w     = cnt_width(max_add_p)
) (
  input  logic             clk,
  input  logic             reset_n_i,
  input  logic [cnt_w-1:0] add_i,
  output logic [ptr_w-1:0] o
);
  localparam int sum_w = ptr_w + 1;
  typedef logic [ptr_w-1:0] ptr_t;

  ptr_t             r_ptr;
  ptr_t             w_ptr_nxt;
  logic [sum_w-1:0] w_sum;

  // One conditional subtract suffices because add_i never exceeds els_p.
  always_comb begin
    w_sum     = sum_w'(r_ptr) + sum_w'(add_i);
    w_ptr_nxt = (w_sum >= sum_w'(els_p)) ? ptr_t'(w_sum - sum_w'(els_p)) : ptr_t'(w_sum);
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) r_ptr <= '0;
    else            r_ptr <= w_ptr_nxt;
  end

  assign o = r_ptr;

endmodule

// File: rtl/bsg_fifo_tracker_multi.sv
// rtl/bsg_fifo_tracker_multi.sv - ring occupancy tracker with multi-entry enqueue/dequeue per cycle
module bsg_fifo_tracker_multi
  import bsg_fifo_tracker_pkg::*;
#(
  parameter int els_p     = 128,
  parameter int max_add_p = 10
) (
  input  logic                      clk,
  input  logic                      reset_n_i,
  bsg_fifo_tracker_multi_if.slave   bus
);
  localparam int cnt_w = cnt_width(max_add_p);
  localparam int occ_w = occ_width(els_p);

  logic [occ_w-1:0] r_occ;
  logic             r_full;
  logic             r_empty;
  logic [occ_w-1:0] w_enq_cnt;
  logic [occ_w-1:0] w_deq_cnt;
  logic [occ_w-1:0] w_free;
  logic [occ_w-1:0] w_enq_k;
  logic [occ_w-1:0] w_deq_k;
  logic [occ_w-1:0] w_occ_nxt;
  logic [cnt_w-1:0] w_enq_add;
  logic [cnt_w-1:0] w_deq_add;
  logic             w_enq_rdy;
  logic             w_deq_rdy;

  // Readies see only registered occupancy; a same-cycle dequeue never frees room for the enqueue.
  always_comb begin
    w_enq_cnt = occ_w'(bus.enq_count_i);
    w_deq_cnt = occ_w'(bus.deq_count_i);
    w_free    = occ_w'(els_p) - r_occ;
    w_enq_rdy = reset_n_i & (w_enq_cnt <= occ_w'(max_add_p)) & (w_enq_cnt <= w_free);
    w_deq_rdy = reset_n_i & (w_deq_cnt <= occ_w'(max_add_p)) & (w_deq_cnt <= r_occ);
    w_enq_add = (bus.enq_v_i & w_enq_rdy) ? bus.enq_count_i : '0;
    w_deq_add = (bus.deq_v_i & w_deq_rdy) ? bus.deq_count_i : '0;
    w_enq_k   = occ_w'(w_enq_add);
    w_deq_k   = occ_w'(w_deq_add);
    w_occ_nxt = r_occ + w_enq_k - w_deq_k;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_occ   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_occ   <= w_occ_nxt;
      r_full  <= (w_occ_nxt == occ_w'(els_p));
      r_empty <= (w_occ_nxt == '0);
    end
  end

  bsg_circ_ptr_arst_n #(.els_p(els_p), .max_add_p(max_add_p)) u_wptr (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .add_i     (w_enq_add),
    .o         (bus.wptr_o)
  );

  bsg_circ_ptr_arst_n #(.els_p(els_p), .max_add_p(max_add_p)) u_rptr (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .add_i     (w_deq_add),
    .o         (bus.rptr_o)
  );

  assign bus.enq_ready_o = w_enq_rdy;
  assign bus.deq_ready_o = w_deq_rdy;
  assign bus.occ_o       = r_occ;
  assign bus.full_o      = r_full;
  assign bus.empty_o     = r_empty;

endmodule
